// File: rtl/context_scheduler_pkg.sv
// Shared types and default constants for the context scheduler.
package sched_pkg;

    localparam int NUM_PROC_DEF      = 4;
    localparam int PROC_ID_W         = $clog2(NUM_PROC_DEF);
    localparam int PROC_STRIDE_DEF   = 512;
    localparam int DEFAULT_SLICE_DEF = 1000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_IDLE   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/context_scheduler_rr_pick.sv
// Round-robin next-eligible finder: scans cur+1, cur+2, ... with wrap, trying cur itself last.
module rr_pick
    import sched_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF
) (
    input  logic [NUM_PROC-1:0]         elig,
    input  logic [$clog2(NUM_PROC)-1:0] cur,
    output logic [$clog2(NUM_PROC)-1:0] next_idx,
    output logic                        valid
);

    localparam int ID_W = $clog2(NUM_PROC);

    logic [ID_W-1:0] cand;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        next_idx = cur;
        valid    = 1'b0;
        cand     = cur;
        for (int k = 1; k <= NUM_PROC; k++) begin
            // NUM_PROC is a power of two, so the narrow add wraps modulo NUM_PROC; k == NUM_PROC lands on cur
            cand = cur + ID_W'(k);
            if (!valid && elig[cand]) begin
                next_idx = cand;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/context_scheduler.sv
// Preemptive round-robin context scheduler with a per-process saved-PC table.
// Quantum counter and expiry preemption exist only when CTX_SCHED_PREEMPT_EN is defined.
module context_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_PROC      = NUM_PROC_DEF,
    parameter int PC_W          = 13,
    parameter int SLICE_W       = 16,
    parameter int PROC_STRIDE   = PROC_STRIDE_DEF,
    parameter int DEFAULT_SLICE = DEFAULT_SLICE_DEF
) (
    input  logic                        Slow_Clock,
    input  logic                        Reset,
    input  logic                        Enable,
    input  logic [NUM_PROC-1:0]         Ready_Mask,
    input  logic                        Slice_Load,
    input  logic [SLICE_W-1:0]          Slice_Value,
    input  logic                        Sw_Req,
    input  logic [$clog2(NUM_PROC)-1:0] Sw_Target,
    input  logic                        Halt,
    input  logic [PC_W-1:0]             Cur_PC,
    output logic                        Switch,
    output logic [PC_W-1:0]             Ctx_PC,
    output logic [$clog2(NUM_PROC)-1:0] Proc_ID,
    output logic [NUM_PROC-1:0]         Done_Mask,
    output logic                        Idle,
    output logic [SLICE_W-1:0]          Slice_Count
);

    localparam int ID_W = $clog2(NUM_PROC);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    proc_id_q, proc_id_d;
    logic [ID_W-1:0]    next_q, next_d;
    logic               switch_q, switch_d;
    logic [PC_W-1:0]    ctx_pc_q, ctx_pc_d;
    logic               idle_q, idle_d;
    logic [NUM_PROC-1:0] done_q, done_d;
    logic               from_idle_q, from_idle_d;
    logic [PC_W-1:0]    saved_q [NUM_PROC];
    logic [PC_W-1:0]    saved_d [NUM_PROC];

    logic [NUM_PROC-1:0] elig, cur_bit, pick_mask;
    logic [ID_W-1:0]     pick_idx, sw_tgt;
    logic                pick_valid, sw_hit, sw_self, expiry, reload;
    logic                go_sw, go_idle;

    assign elig    = Ready_Mask & ~done_q;
    assign cur_bit = NUM_PROC'(1) << proc_id_q;
    assign sw_hit  = Sw_Req && elig[Sw_Target] && (Sw_Target != proc_id_q);
    assign sw_self = Sw_Req && (Sw_Target == proc_id_q);

    // A halting process must not be picked again, so it is masked out before the scan.
    assign pick_mask = (state_q == ST_RUN && Halt) ? (elig & ~cur_bit) : elig;

    rr_pick #(
        .NUM_PROC (NUM_PROC)
    ) u_rr_pick (
        .elig     (pick_mask),
        .cur      (proc_id_q),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        proc_id_d   = proc_id_q;
        next_d      = next_q;
        switch_d    = 1'b0;
        ctx_pc_d    = ctx_pc_q;
        idle_d      = idle_q;
        done_d      = done_q;
        from_idle_d = from_idle_q;
        saved_d     = saved_q;
        reload      = 1'b0;
        go_sw       = 1'b0;
        go_idle     = 1'b0;
        sw_tgt      = pick_idx;

        unique case (state_q)
            ST_RUN: begin
                if (Halt) begin
                    done_d[proc_id_q] = 1'b1;
                    if (pick_valid) go_sw   = 1'b1;
                    else            go_idle = 1'b1;
                end else if (sw_hit) begin
                    go_sw  = 1'b1;
                    sw_tgt = Sw_Target;
                end else if (sw_self) begin
                    reload = 1'b1;
                end else if (expiry) begin
                    if (!pick_valid)                  go_idle = 1'b1;
                    else if (pick_idx != proc_id_q)   go_sw   = 1'b1;
                    else                              reload  = 1'b1;
                end
            end
            ST_SWITCH: begin
                state_d   = ST_RUN;
                proc_id_d = next_q;
                reload    = 1'b1;
                // Coming out of IDLE the outgoing PC was already saved when the core stalled
                if (!from_idle_q) saved_d[proc_id_q] = Cur_PC;
            end
            ST_IDLE: begin
                if (pick_valid) go_sw = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        if (go_sw) begin
            state_d     = ST_SWITCH;
            switch_d    = 1'b1;
            next_d      = sw_tgt;
            ctx_pc_d    = saved_q[sw_tgt];
            idle_d      = 1'b0;
            from_idle_d = (state_q == ST_IDLE);
        end
        if (go_idle) begin
            state_d            = ST_IDLE;
            idle_d             = 1'b1;
            saved_d[proc_id_q] = Cur_PC;
        end
    end

    always_ff @(posedge Slow_Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_RUN;
            proc_id_q   <= '0;
            next_q      <= '0;
            switch_q    <= 1'b0;
            ctx_pc_q    <= '0;
            idle_q      <= 1'b0;
            done_q      <= '0;
            from_idle_q <= 1'b0;
            // NOTE: the saved-PC table is a handful of flops with defined per-slot start PCs, so it takes reset like any register.
            for (int i = 0; i < NUM_PROC; i++) begin
                saved_q[i] <= PC_W'(i * PROC_STRIDE);
            end
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            proc_id_q   <= proc_id_d;
            next_q      <= next_d;
            switch_q    <= switch_d;
            ctx_pc_q    <= ctx_pc_d;
            idle_q      <= idle_d;
            done_q      <= done_d;
            from_idle_q <= from_idle_d;
            saved_q     <= saved_d;
        end
    end

`ifdef CTX_SCHED_PREEMPT_EN
    logic [SLICE_W-1:0] slice_q, slice_d;
    logic [SLICE_W-1:0] count_q, count_d;

    // A same-cycle Slice_Load feeds the reload directly; a zero quantum behaves as one cycle.
    always_comb begin
        slice_d = Slice_Load ? Slice_Value : slice_q;
        count_d = count_q;
        if (reload) begin
            count_d = (slice_d == '0) ? '0 : slice_d - 1'b1;
        end else if (state_q == ST_RUN && Enable && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Slow_Clock or negedge Reset) begin
        if (!Reset) begin
            slice_q <= SLICE_W'(DEFAULT_SLICE);
            count_q <= SLICE_W'(DEFAULT_SLICE - 1);
        end else begin
            slice_q <= slice_d;
            count_q <= count_d;
        end
    end

    assign expiry      = (state_q == ST_RUN) && Enable && (count_q == '0);
    assign Slice_Count = count_q;
`else
    logic unused_slice;

    assign unused_slice = ^{Enable, Slice_Load, Slice_Value, reload};
    assign expiry       = 1'b0;
    assign Slice_Count  = '0;
`endif

    assign Switch    = switch_q;
    assign Ctx_PC    = ctx_pc_q;
    assign Proc_ID   = proc_id_q;
    assign Done_Mask = done_q;
    assign Idle      = idle_q;

endmodule

// File: tb/tb_context_scheduler.sv
// Scoreboard bench for context_scheduler; expiry scenarios run when CTX_SCHED_PREEMPT_EN is defined.
module tb_context_scheduler;
    import sched_pkg::*;

`ifdef CTX_SCHED_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    typedef struct packed {
        logic [12:0]          ctx;
        logic [PROC_ID_W-1:0] id;
        logic                 from_idle;
    } sb_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic [3:0]           ready_mask;
    logic                 slice_load;
    logic [15:0]          slice_value;
    logic                 sw_req;
    logic [PROC_ID_W-1:0] sw_target;
    logic                 halt;
    logic [12:0]          cur_pc = 13'h0100;
    logic                 sw_out;
    logic [12:0]          ctx_pc;
    logic [PROC_ID_W-1:0] proc_id;
    logic [3:0]           done_mask;
    logic                 idle;
    logic [15:0]          slice_count;

    int checks   = 0;
    int failures = 0;

    sb_t                  sb_q[$];
    logic [12:0]          m_saved [4];
    logic [PROC_ID_W-1:0] m_cur;

    always #5 clk = ~clk;

    // The core's next PC keeps moving so every captured value is distinct.
    always @(posedge clk) cur_pc <= cur_pc + 13'd37;

    context_scheduler dut (
        .Slow_Clock  (clk),
        .Reset       (reset_n),
        .Enable      (enable),
        .Ready_Mask  (ready_mask),
        .Slice_Load  (slice_load),
        .Slice_Value (slice_value),
        .Sw_Req      (sw_req),
        .Sw_Target   (sw_target),
        .Halt        (halt),
        .Cur_PC      (cur_pc),
        .Switch      (sw_out),
        .Ctx_PC      (ctx_pc),
        .Proc_ID     (proc_id),
        .Done_Mask   (done_mask),
        .Idle        (idle),
        .Slice_Count (slice_count)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_saved[i] = 13'(i * 512);
        m_cur = '0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        tick();
        reset_n     = 1'b0;
        enable      = 1'b1;
        ready_mask  = 4'b0000;
        slice_load  = 1'b0;
        slice_value = 16'd0;
        sw_req      = 1'b0;
        sw_target   = '0;
        halt        = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic push_exp(input logic [12:0] ctx, input logic [PROC_ID_W-1:0] id, input logic fi);
        sb_t e;
        e.ctx       = ctx;
        e.id        = id;
        e.from_idle = fi;
        sb_q.push_back(e);
    endtask

    task automatic drive_sw(input logic [PROC_ID_W-1:0] t);
        sw_req    = 1'b1;
        sw_target = t;
        tick();
        sw_req    = 1'b0;
    endtask

    // Waits for Switch, pops the scoreboard and checks latency, Ctx_PC, the new Proc_ID and the single-cycle pulse.
    task automatic wait_switch(input string name, input int exp_wait);
        int  n;
        sb_t e;
        n = 0;
        while (sw_out !== 1'b1 && n <= exp_wait + 2) begin
            tick();
            n++;
        end
        checks++;
        if (sw_out !== 1'b1) begin
            failures++;
            $display("FAIL %s: Switch still low after %0d cycles, required after %0d", name, n, exp_wait);
            sb_q.delete();
            return;
        end
        checks++;
        if (n != exp_wait) begin
            failures++;
            $display("FAIL %s_latency: Switch after %0d cycles, required %0d", name, n, exp_wait);
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: Switch seen with no expected entry", name);
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (ctx_pc !== e.ctx) begin
            failures++;
            $display("FAIL %s_ctx_pc: got %0d required %0d", name, ctx_pc, e.ctx);
        end
        if (!e.from_idle) m_saved[m_cur] = cur_pc;
        m_cur = e.id;
        tick();
        checks++;
        if (proc_id !== e.id) begin
            failures++;
            $display("FAIL %s_proc_id: got %0d required %0d", name, proc_id, e.id);
        end
        checks++;
        if (sw_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse: Switch got %0b required 0", name, sw_out);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (sw_out !== 1'b0)    begin failures++; $display("FAIL reset_switch: got %0b required 0", sw_out); end
        if (ctx_pc !== 13'd0)   begin failures++; $display("FAIL reset_ctx_pc: got %0d required 0", ctx_pc); end
        if (proc_id !== 2'd0)   begin failures++; $display("FAIL reset_proc_id: got %0d required 0", proc_id); end
        if (idle !== 1'b0)      begin failures++; $display("FAIL reset_idle: got %0b required 0", idle); end
        if (done_mask !== 4'd0) begin failures++; $display("FAIL reset_done: got %b required 0000", done_mask); end
        if (slice_count !== (PREEMPT ? 16'd999 : 16'd0)) begin
            failures++;
            $display("FAIL reset_slice_count: got %0d required %0d", slice_count, PREEMPT ? 999 : 0);
        end
    endtask

    task automatic test_sw_req();
        do_reset();
        ready_mask = 4'b1111;
        push_exp(13'd1024, 2'd2, 1'b0);
        drive_sw(2'd2);
        wait_switch("sw_to_2", 0);
        push_exp(m_saved[0], 2'd0, 1'b0);
        drive_sw(2'd0);
        wait_switch("sw_back_0", 0);
        push_exp(m_saved[2], 2'd2, 1'b0);
        drive_sw(2'd2);
        wait_switch("sw_again_2", 0);
    endtask

    task automatic test_sw_ignored();
        int seen;
        seen = 0;
        do_reset();
        ready_mask = 4'b1011;
        sw_req     = 1'b1;
        sw_target  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            sw_req = 1'b0;
            if (sw_out === 1'b1) seen++;
        end
        checks += 3;
        if (seen != 0)        begin failures++; $display("FAIL sw_ineligible_switch: got %0d pulses required 0", seen); end
        if (proc_id !== 2'd0) begin failures++; $display("FAIL sw_ineligible_proc_id: got %0d required 0", proc_id); end
        if (slice_count !== (PREEMPT ? 16'd996 : 16'd0)) begin
            failures++;
            $display("FAIL sw_ineligible_count: got %0d required %0d", slice_count, PREEMPT ? 996 : 0);
        end
        drive_sw(2'd0);
        checks += 2;
        if (sw_out !== 1'b0) begin failures++; $display("FAIL sw_self_switch: got %0b required 0", sw_out); end
        if (slice_count !== (PREEMPT ? 16'd999 : 16'd0)) begin
            failures++;
            $display("FAIL sw_self_reload: got %0d required %0d", slice_count, PREEMPT ? 999 : 0);
        end
    endtask

    task automatic test_halt_idle();
        do_reset();
        ready_mask = 4'b0001;
        halt       = 1'b1;
        m_saved[0] = cur_pc;
        tick();
        halt = 1'b0;
        checks += 3;
        if (done_mask !== 4'b0001) begin failures++; $display("FAIL halt_done: got %b required 0001", done_mask); end
        if (idle !== 1'b1)         begin failures++; $display("FAIL halt_idle: got %0b required 1", idle); end
        if (sw_out !== 1'b0)       begin failures++; $display("FAIL halt_switch: got %0b required 0", sw_out); end
        tick();
        tick();
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL idle_hold: got %0b required 1", idle); end
        ready_mask = 4'b0101;
        push_exp(m_saved[2], 2'd2, 1'b1);
        tick();
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL idle_wake_idle: got %0b required 0", idle); end
        wait_switch("idle_wake", 0);
        ready_mask = 4'b1111;
        halt       = 1'b1;
        push_exp(m_saved[3], 2'd3, 1'b0);
        tick();
        halt = 1'b0;
        wait_switch("halt_to_3", 0);
        checks++;
        if (done_mask !== 4'b0101) begin failures++; $display("FAIL halt_done2: got %b required 0101", done_mask); end
    endtask

    task automatic test_reset_mid_switch();
        do_reset();
        ready_mask = 4'b1111;
        push_exp(13'd512, 2'd1, 1'b0);
        drive_sw(2'd1);
        wait_switch("pre_rst_1", 0);
        push_exp(13'd1024, 2'd2, 1'b0);
        drive_sw(2'd2);
        wait_switch("pre_rst_2", 0);
        drive_sw(2'd3);
        checks++;
        if (sw_out !== 1'b1) begin failures++; $display("FAIL mid_rst_switch_before: got %0b required 1", sw_out); end
        #1 reset_n = 1'b0;
        #1;
        checks += 3;
        if (sw_out !== 1'b0)  begin failures++; $display("FAIL mid_rst_switch: got %0b required 0", sw_out); end
        if (proc_id !== 2'd0) begin failures++; $display("FAIL mid_rst_proc_id: got %0d required 0", proc_id); end
        if (ctx_pc !== 13'd0) begin failures++; $display("FAIL mid_rst_ctx_pc: got %0d required 0", ctx_pc); end
        #1 reset_n = 1'b1;
        model_reset();
        push_exp(13'd512, 2'd1, 1'b0);
        drive_sw(2'd1);
        wait_switch("post_rst_saved1", 0);
    endtask

    task automatic test_slice_inputs_idle_path();
        int seen;
        seen = 0;
        do_reset();
        ready_mask  = 4'b0011;
        slice_load  = 1'b1;
        slice_value = 16'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sw_out === 1'b1) seen++;
        end
        slice_load = 1'b0;
        checks += 2;
        if (seen != 0) begin failures++; $display("FAIL slice_load_no_switch: got %0d pulses required 0", seen); end
        if (slice_count !== (PREEMPT ? 16'd991 : 16'd0)) begin
            failures++;
            $display("FAIL slice_load_count: got %0d required %0d", slice_count, PREEMPT ? 991 : 0);
        end
    endtask

`ifdef CTX_SCHED_PREEMPT_EN
    task automatic set_quantum4();
        slice_load  = 1'b1;
        slice_value = 16'd4;
        drive_sw(m_cur);
        slice_load = 1'b0;
        checks++;
        if (slice_count !== 16'd3) begin failures++; $display("FAIL q4_reload: got %0d required 3", slice_count); end
    endtask

    task automatic test_expiry();
        do_reset();
        ready_mask = 4'b0011;
        set_quantum4();
        push_exp(13'd512, 2'd1, 1'b0);
        wait_switch("expiry_1", 4);
        push_exp(m_saved[0], 2'd0, 1'b0);
        wait_switch("expiry_2", 4);
    endtask

    task automatic test_sw_vs_expiry();
        do_reset();
        ready_mask = 4'b1111;
        set_quantum4();
        tick();
        tick();
        tick();
        checks++;
        if (slice_count !== 16'd0) begin failures++; $display("FAIL expiry_count_zero: got %0d required 0", slice_count); end
        push_exp(13'd1536, 2'd3, 1'b0);
        drive_sw(2'd3);
        wait_switch("sw_over_expiry", 0);
        tick();
        tick();
        tick();
        slice_load  = 1'b1;
        slice_value = 16'd2;
        push_exp(m_saved[0], 2'd0, 1'b0);
        tick();
        slice_load = 1'b0;
        wait_switch("load_on_expiry", 0);
        checks++;
        if (slice_count !== 16'd1) begin failures++; $display("FAIL load_on_expiry_count: got %0d required 1", slice_count); end
        push_exp(13'd512, 2'd1, 1'b0);
        wait_switch("short_run", 2);
    endtask

    task automatic test_enable_freeze();
        do_reset();
        ready_mask = 4'b0011;
        enable     = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (slice_count !== 16'd999) begin failures++; $display("FAIL freeze_count: got %0d required 999", slice_count); end
        enable = 1'b1;
        tick();
        checks++;
        if (slice_count !== 16'd998) begin failures++; $display("FAIL resume_count: got %0d required 998", slice_count); end
    endtask
`endif

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        ready_mask  = 4'b0000;
        slice_load  = 1'b0;
        slice_value = 16'd0;
        sw_req      = 1'b0;
        sw_target   = '0;
        halt        = 1'b0;
        test_reset();
        test_sw_req();
        test_sw_ignored();
        test_halt_idle();
        test_reset_mid_switch();
        test_slice_inputs_idle_path();
`ifdef CTX_SCHED_PREEMPT_EN
        test_expiry();
        test_sw_vs_expiry();
        test_enable_freeze();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
